// File: rtl/pipeline_stall_ctrl_if.sv
// Stall-controller bus: ID source reads, EX instruction info, flush request
// and the stall/flush/done outputs driven back to the pipeline.
//   master : pipeline side (drives *_i, observes *_o)
//   slave  : pipeline_stall_ctrl (observes *_i, drives *_o)
interface pipeline_stall_ctrl_if #(
  parameter int unsigned MULTI_W = 6
);
  logic               id_reg1_read_i;
  logic               id_reg2_read_i;
  logic [4:0]         id_reg1_addr_i;
  logic [4:0]         id_reg2_addr_i;
  logic               ex_is_load_i;
  logic               ex_wreg_i;
  logic [4:0]         ex_wd_i;
  logic               ex_multi_start_i;
  logic [MULTI_W-1:0] ex_multi_cycles_i;
  logic               flush_req_i;
  logic [5:0]         stall_o;
  logic               flush_o;
  logic               multi_done_o;
  logic               busy_o;
  logic [31:0]        stall_cycles_o;

  modport master (
    output id_reg1_read_i, id_reg2_read_i, id_reg1_addr_i, id_reg2_addr_i,
           ex_is_load_i, ex_wreg_i, ex_wd_i, ex_multi_start_i,
           ex_multi_cycles_i, flush_req_i,
    input  stall_o, flush_o, multi_done_o, busy_o, stall_cycles_o
  );

  modport slave (
    input  id_reg1_read_i, id_reg2_read_i, id_reg1_addr_i, id_reg2_addr_i,
           ex_is_load_i, ex_wreg_i, ex_wd_i, ex_multi_start_i,
           ex_multi_cycles_i, flush_req_i,
    output stall_o, flush_o, multi_done_o, busy_o, stall_cycles_o
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Detects load-use hazards, sequences multi-cycle EX ops (RUN/MULTI/DONE)
// and applies flush requests. stall_o/flush_o/multi_done_o are combinational.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - pipeline_stall_ctrl_if.slave (hazard inputs, stall/flush outputs)
// Optional macro STALL_CTRL_PERF_EN: enables the saturating stall-cycle
// counter on bus.stall_cycles_o; otherwise that output is tied to zero.
module pipeline_stall_ctrl #(
  parameter int unsigned MULTI_W = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  pipeline_stall_ctrl_if.slave        bus
);

  typedef enum logic [1:0] {RUN, MULTI, DONE} state_e;

  localparam logic [5:0] STALL_MULTI = 6'b001111;
  localparam logic [5:0] STALL_LU    = 6'b000111;

  state_e             state_q, state_d;
  logic [MULTI_W-1:0] cnt_q, cnt_d;
  logic [MULTI_W-1:0] neff;
  logic               lu;
  logic [5:0]         stall;
  logic               flush;
  logic               done;

  always_comb begin
    lu = bus.ex_is_load_i && bus.ex_wreg_i && (bus.ex_wd_i != 5'd0) &&
         ((bus.id_reg1_read_i && (bus.id_reg1_addr_i == bus.ex_wd_i)) ||
          (bus.id_reg2_read_i && (bus.id_reg2_addr_i == bus.ex_wd_i)));
    // N=0 behaves as a one-cycle op
    neff = (bus.ex_multi_cycles_i == '0) ? MULTI_W'(1) : bus.ex_multi_cycles_i;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = '0;
    flush   = 1'b0;
    done    = 1'b0;
    if (rst) begin
      state_d = RUN;
      cnt_d   = '0;
    end else if (bus.flush_req_i) begin
      // aborts any multi-cycle op without a done pulse
      flush   = 1'b1;
      state_d = RUN;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (bus.ex_multi_start_i) begin
            stall   = STALL_MULTI;
            cnt_d   = neff - MULTI_W'(1);
            state_d = (neff == MULTI_W'(1)) ? DONE : MULTI;
          end else if (lu) begin
            stall = STALL_LU;
          end
        end
        MULTI: begin
          stall = STALL_MULTI;
          cnt_d = cnt_q - MULTI_W'(1);
          if (cnt_q == MULTI_W'(1)) state_d = DONE;
        end
        DONE: begin
          // start is still high for the finished op; only LU matters here
          done    = 1'b1;
          state_d = RUN;
          if (lu) stall = STALL_LU;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
  end

  assign bus.stall_o      = stall;
  assign bus.flush_o      = flush;
  assign bus.multi_done_o = done;
  assign bus.busy_o       = !rst && (state_q != RUN);

`ifdef STALL_CTRL_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (rst)
      stall_cycles_d = '0;
    else if ((stall != '0) && (stall_cycles_q != '1))
      stall_cycles_d = stall_cycles_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    stall_cycles_q <= stall_cycles_d;
  end

  assign bus.stall_cycles_o = stall_cycles_q;
`else
  assign bus.stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
module tb_pipeline_stall_ctrl;

  localparam int unsigned MW = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [5:0] last_stall_exp = '0;
  int   perf_exp = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl_if #(.MULTI_W(MW)) bus ();

  pipeline_stall_ctrl #(.MULTI_W(MW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // check all combinational outputs plus busy; remember expected stall for perf model
  task automatic chk_out(input string tag, input logic [5:0] st, input logic fl,
                         input logic dn, input logic bz);
    chk({tag, ".stall"}, 32'(bus.stall_o), 32'(st));
    chk({tag, ".flush"}, 32'(bus.flush_o), 32'(fl));
    chk({tag, ".done"},  32'(bus.multi_done_o), 32'(dn));
    chk({tag, ".busy"},  32'(bus.busy_o), 32'(bz));
    last_stall_exp = st;
  endtask

  task automatic chk_perf(input string tag);
`ifdef STALL_CTRL_PERF_EN
    chk(tag, bus.stall_cycles_o, 32'(perf_exp));
`else
    chk(tag, bus.stall_cycles_o, 32'h0);
`endif
  endtask

  task automatic tick;
    @(posedge clk);
    if (rst) perf_exp = 0;
    else if (last_stall_exp != '0) perf_exp++;
    last_stall_exp = '0;
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic clear_in;
    bus.id_reg1_read_i    = 1'b0;
    bus.id_reg2_read_i    = 1'b0;
    bus.id_reg1_addr_i    = '0;
    bus.id_reg2_addr_i    = '0;
    bus.ex_is_load_i      = 1'b0;
    bus.ex_wreg_i         = 1'b0;
    bus.ex_wd_i           = '0;
    bus.ex_multi_start_i  = 1'b0;
    bus.ex_multi_cycles_i = '0;
    bus.flush_req_i       = 1'b0;
  endtask

  task automatic set_load(input logic [4:0] wd, input logic r1, input logic [4:0] a1,
                          input logic r2, input logic [4:0] a2);
    bus.ex_is_load_i   = 1'b1;
    bus.ex_wreg_i      = 1'b1;
    bus.ex_wd_i        = wd;
    bus.id_reg1_read_i = r1;
    bus.id_reg1_addr_i = a1;
    bus.id_reg2_read_i = r2;
    bus.id_reg2_addr_i = a2;
  endtask

  task automatic start_op(input logic [MW-1:0] n);
    bus.ex_multi_start_i  = 1'b1;
    bus.ex_multi_cycles_i = n;
  endtask

  initial begin
    clear_in();
    tick(); tick();
    settle();
    chk_out("reset", 6'b0, 1'b0, 1'b0, 1'b0);
    chk_perf("reset.perf");
    rst = 1'b0;
    tick();

    // load-use via port 2, r3
    set_load(5'd3, 1'b0, 5'd0, 1'b1, 5'd3);
    settle();
    chk_out("lu_p2", 6'b000111, 1'b0, 1'b0, 1'b0);
    tick();
    clear_in();                      // bubble now in EX, load in MEM
    settle();
    chk_out("lu_after", 6'b0, 1'b0, 1'b0, 1'b0);
    // same with wd=0: no hazard
    set_load(5'd0, 1'b0, 5'd0, 1'b1, 5'd0);
    settle();
    chk("lu_r0", 32'(bus.stall_o), 32'h0);
    // match on port 1 with read disabled: no hazard
    set_load(5'd7, 1'b0, 5'd7, 1'b0, 5'd0);
    settle();
    chk("lu_noread", 32'(bus.stall_o), 32'h0);
    // non-writing load: no hazard
    set_load(5'd7, 1'b1, 5'd7, 1'b0, 5'd0);
    bus.ex_wreg_i = 1'b0;
    settle();
    chk("lu_nowreg", 32'(bus.stall_o), 32'h0);
    tick();
    clear_in();

    // multi N=4 at T
    start_op(6'd4);
    settle();
    chk_out("m4_T", 6'b001111, 1'b0, 1'b0, 1'b0);
    for (int unsigned i = 1; i <= 3; i++) begin
      tick();
      chk_out($sformatf("m4_T%0d", i), 6'b001111, 1'b0, 1'b0, 1'b1);
    end
    tick();
    chk_out("m4_T4", 6'b0, 1'b0, 1'b1, 1'b1);
    tick();
    clear_in();
    settle();
    chk_out("m4_T5", 6'b0, 1'b0, 1'b0, 1'b0);
    chk_perf("perf_lu_m4");          // 1 LU + 4 multi = 5

    // N=0 and N=1 both one stall cycle
    for (int unsigned k = 0; k < 2; k++) begin
      start_op(MW'(k));
      settle();
      chk_out($sformatf("n%0d_T", k), 6'b001111, 1'b0, 1'b0, 1'b0);
      tick();
      chk_out($sformatf("n%0d_T1", k), 6'b0, 1'b0, 1'b1, 1'b1);
      tick();
      clear_in();
      settle();
      chk_out($sformatf("n%0d_T2", k), 6'b0, 1'b0, 1'b0, 1'b0);
    end

    // flush at second MULTI cycle of N=8
    start_op(6'd8);
    settle();
    chk_out("fl_T", 6'b001111, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("fl_T1", 6'b001111, 1'b0, 1'b0, 1'b1);
    tick();
    bus.flush_req_i = 1'b1;
    settle();
    chk_out("fl_T2", 6'b0, 1'b1, 1'b0, 1'b1);
    tick();
    clear_in();
    settle();
    chk_out("fl_T3", 6'b0, 1'b0, 1'b0, 1'b0);

    // flush beats start in RUN
    start_op(6'd3);
    bus.flush_req_i = 1'b1;
    settle();
    chk_out("fl_run", 6'b0, 1'b1, 1'b0, 1'b0);
    tick();
    clear_in();

    // start held through DONE, LU in DONE
    start_op(6'd2);
    settle();
    chk_out("hd_T", 6'b001111, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("hd_T1", 6'b001111, 1'b0, 1'b0, 1'b1);
    tick();
    set_load(5'd9, 1'b1, 5'd9, 1'b0, 5'd0);
    settle();
    chk_out("hd_T2", 6'b000111, 1'b0, 1'b1, 1'b1);
    tick();
    clear_in();
    settle();
    chk_out("hd_T3", 6'b0, 1'b0, 1'b0, 1'b0);
    chk_perf("perf_mid");

    // sync reset during MULTI
    start_op(6'd8);
    settle();
    chk_out("rs_T", 6'b001111, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    settle();
    chk_out("rs_in", 6'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    clear_in();
    settle();
    chk_out("rs_after", 6'b0, 1'b0, 1'b0, 1'b0);
    chk_perf("rs_perf");
    start_op(6'd3);
    settle();
    chk_out("rs_new", 6'b001111, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("rs_new1", 6'b001111, 1'b0, 1'b0, 1'b1);
    tick();
    chk_out("rs_new2", 6'b001111, 1'b0, 1'b0, 1'b1);
    tick();
    chk_out("rs_new3", 6'b0, 1'b0, 1'b1, 1'b1);
    tick();
    clear_in();
    settle();
    chk_out("rs_new4", 6'b0, 1'b0, 1'b0, 1'b0);
    chk_perf("perf_end");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Central stall and flush sequencer for the 5-stage pipeline (PC, IF, ID, EX, MEM, WB). It watches the ID-stage source-register reads and the EX-stage instruction, and detects load-use hazards that forwarding cannot cover. It sequences multi-cycle EX operations such as divide, and applies external flush requests. It drives the per-stage stall vector consumed by pc_reg and every pipeline register.

## Interface
Parameters:
- MULTI_W, 6, width of the multi-cycle length field; max length 2^MULTI_W-1 cycles.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- id_reg1_read_i  in  1  ID uses source port 1.
- id_reg2_read_i  in  1  ID uses source port 2.
- id_reg1_addr_i  in  5  ID source 1 register.
- id_reg2_addr_i  in  5  ID source 2 register.
- ex_is_load_i  in  1  EX instruction is a load.
- ex_wreg_i  in  1  EX instruction writes a register.
- ex_wd_i  in  5  EX destination register.
- ex_multi_start_i  in  1  EX holds a multi-cycle op; held high while the op sits in EX.
- ex_multi_cycles_i  in  MULTI_W  stall length N for that op.
- flush_req_i  in  1  flush request, e.g. from an exception.
- stall_o  out  6  stall vector; bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
- flush_o  out  1  clear all pipeline registers this cycle.
- multi_done_o  out  1  multi-cycle op completes; EX result valid.
- busy_o  out  1  FSM not in RUN.
- stall_cycles_o  out  32  stall-cycle counter (see Configuration).

## Operation
- FSM states: RUN, MULTI, DONE. Counter cnt is MULTI_W bits.
- Load-use hazard (LU) is asserted when all of the following hold:
  - ex_is_load_i and ex_wreg_i are 1;
  - ex_wd_i is not 0;
  - either id_reg1_read_i=1 with id_reg1_addr_i==ex_wd_i, or id_reg2_read_i=1 with id_reg2_addr_i==ex_wd_i.
- Priority per cycle: rst > flush_req_i > multi-cycle stall > LU.
- Flush (any state):
  - stall_o=0, flush_o=1 in the same cycle;
  - next state RUN, cnt<=0;
  - a multi-cycle op in progress is aborted with no multi_done_o pulse.
- RUN:
  - If ex_multi_start_i=1: Neff=max(N,1) and stall_o=6'b001111.
    - Load cnt<=Neff-1.
    - If Neff==1, next state is DONE. Otherwise next state is MULTI.
  - Else if LU: stall_o=6'b000111 for that cycle. EX receives a bubble from id_ex, and the FSM stays in RUN.
  - Else stall_o=0.
- MULTI:
  - stall_o=6'b001111; cnt<=cnt-1.
  - When cnt==1, next state is DONE.
  - ex_multi_start_i and LU are ignored.
- DONE:
  - multi_done_o=1 and the multi stall is released.
  - ex_multi_start_i is ignored because it still refers to the finished op.
  - LU is evaluated as in RUN.
  - Next state RUN.
- busy_o = (state != RUN).
- Register 0 never causes a hazard.

## Timing
- Reset values: state RUN, cnt 0, stall_o 0, flush_o 0, multi_done_o 0, busy_o 0, stall_cycles_o 0.
- stall_o, flush_o and multi_done_o are combinational from the current state and inputs, with no registered latency. State and cnt update on the clock edge.
- Multi-cycle op:
  - start seen at cycle T gives stall_o=001111 on cycles T..T+Neff-1;
  - multi_done_o=1 and stall released at T+Neff;
  - RUN from T+Neff+1.
- LU stall lasts exactly one cycle per hazard. On the next cycle the load is in MEM and ID forwarding supplies the data.
- A start and an LU in the same RUN cycle produce 001111, since the multi stall is a superset.
- rst asserted mid-operation returns everything to reset values at the next edge; outputs are 0 while rst=1.

## Configuration
- STALL_CTRL_PERF_EN defined:
  - stall_cycles_o increments on every non-reset cycle with stall_o != 0;
  - it saturates at 32'hFFFFFFFF;
  - it is cleared by rst only.
- STALL_CTRL_PERF_EN undefined: no counter register; stall_cycles_o is tied to 32'h0 and the port remains.

## Test plan
- LU hazard: EX load to r3 (is_load=1, wreg=1, wd=3), ID reads r3 on port 2 -> stall_o=000111 for exactly 1 cycle, then 000000. The same stimulus with wd=0 -> no stall.
- Multi-cycle: start with N=4 at cycle T -> stall_o=001111 on T..T+3, multi_done_o=1 at T+4 only, busy_o=1 on T+1..T+4, RUN at T+5. N=0 and N=1 both give 1 stall cycle and done at T+1.
- Flush at the second MULTI cycle of an N=8 op -> flush_o=1, stall_o=0 that cycle, no multi_done_o pulse, busy_o=0 next cycle.
- Start held high through DONE, plus LU in DONE -> no restart; stall_o=000111 in DONE, multi_done_o=1.
- Sync reset asserted during MULTI -> all outputs 0 after the edge, and a new start is accepted on the first cycle after rst deasserts.
- With STALL_CTRL_PERF_EN: one LU stall plus an N=4 op -> stall_cycles_o=5. Without the macro -> stall_cycles_o=0.
